// File: rtl/histo_pkg.sv
// Shared definitions for the histogram engine: state encoding, bin-count helper and
// a saturating adder used by the accumulator and cumulative sweeps.
package histo_pkg;

  typedef enum logic [1:0] {
    StInit = 2'd0,
    StAcc  = 2'd1,
    StDump = 2'd2
  } state_e;

  function automatic int unsigned nbins(input int unsigned bin_w);
    return 32'd1 << bin_w;
  endfunction

  // Result clamps to 2^w-1; callers cast the result down to w bits (w <= 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] max_val;
    sum     = {1'b0, a} + {1'b0, b};
    max_val = (33'd1 << w) - 33'd1;
    return (sum > max_val) ? max_val[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/histo_dpram.sv
// Simple dual-port RAM: one write port, one registered read port returning old data
// when the same address is written in the same cycle.
module histo_dpram
  import histo_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  localparam int unsigned Depth = nbins(DEPTH_LOG2);

  logic [WIDTH-1:0] r_mem [Depth];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/histo_engine.sv
// Per-frame intensity histogram with a combined publish/clear sweep at frame end.
// Optional peak-bin tracking is enabled by defining HISTO_PEAK_EN.
module histo_engine
  import histo_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned BIN_W = 8,
  parameter int unsigned CNT_W = 20,
  parameter int unsigned CUM_W = 24
) (
  input  logic             iPclk,
  input  logic             iRst,
  input  logic             iFval,
  input  logic             iDval,
  input  logic [PIX_W-1:0] iPix,
  input  logic [BIN_W-1:0] iRd_bin,
  input  logic [CUM_W-1:0] iBar_lvl,
  output logic [CNT_W-1:0] oHist,
  output logic [CUM_W-1:0] oCum,
  output logic             oHist_bar,
  output logic             oCum_bar,
  output logic             oReady,
  output logic             oFrame_done,
  output logic             oSkip,
  output logic [1:0]       oState,
  output logic [BIN_W-1:0] oPeak_bin,
  output logic [CNT_W-1:0] oPeak_cnt
);

  localparam int unsigned NBins = nbins(BIN_W);
  localparam logic [BIN_W:0] CntLast = (BIN_W+1)'(NBins);
  localparam logic [BIN_W:0] CntInitEnd = (BIN_W+1)'(NBins - 1);

  state_e           r_state, w_state_next;
  logic [BIN_W:0]   r_cnt, w_cnt_next;
  logic             r_fval, r_armed, r_skip_pend;
  logic             r_v1;
  logic [BIN_W-1:0] r_bin1;
  logic             r_wv;
  logic [BIN_W-1:0] r_wbin;
  logic [CNT_W-1:0] r_wdat;
  logic             r_dv1;
  logic [BIN_W-1:0] r_dbin1;
  logic [CUM_W-1:0] r_cum_acc;
  logic [CNT_W-1:0] r_hist;
  logic [CUM_W-1:0] r_cum;
  logic             r_hist_bar, r_cum_bar, r_ready, r_frame_done, r_skip;

  logic             w_rise, w_fall, w_in_acc, w_in_init, w_pix_v, w_dump_rd, w_dump_last;
  logic [BIN_W-1:0] w_pix_bin;
  logic [CNT_W-1:0] w_acc_q, w_acc_base, w_acc_inc, w_acc_wdata, w_hist_q, w_hist_wdata;
  logic [CUM_W-1:0] w_cum_q, w_cum_new, w_cum_wdata;
  logic [BIN_W-1:0] w_acc_raddr, w_acc_waddr, w_disp_waddr;
  logic             w_acc_we, w_disp_we;

  assign w_rise      = iFval & ~r_fval;
  assign w_fall      = ~iFval & r_fval;
  assign w_in_acc    = (r_state == StAcc);
  assign w_in_init   = (r_state == StInit);
  assign w_pix_bin   = iPix[PIX_W-1 -: BIN_W];
  // The rising-edge cycle itself may carry the first pixel of an armed frame.
  assign w_pix_v     = w_in_acc & iFval & iDval & (r_armed | w_rise);
  assign w_dump_rd   = (r_state == StDump) && !r_cnt[BIN_W];
  assign w_dump_last = (r_state == StDump) && (r_cnt == CntLast);

  // A write issued last cycle is not yet visible in this cycle's read data.
  assign w_acc_base = (r_wv && (r_wbin == r_bin1)) ? r_wdat : w_acc_q;
  assign w_acc_inc  = CNT_W'(sat_add(32'(w_acc_base), 32'd1, CNT_W));
  assign w_cum_new  = CUM_W'(sat_add(32'(r_cum_acc), 32'(w_acc_q), CUM_W));

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StInit: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == CntInitEnd) begin
          w_state_next = StAcc;
          w_cnt_next   = '0;
        end
      end
      StAcc: begin
        w_cnt_next = '0;
        if (w_fall && r_armed) begin
          w_state_next = StDump;
        end
      end
      StDump: begin
        w_cnt_next = r_cnt + 1'b1;
        if (w_dump_last) begin
          w_state_next = StAcc;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = StInit;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    w_acc_raddr  = w_pix_bin;
    w_acc_we     = 1'b0;
    w_acc_waddr  = r_bin1;
    w_acc_wdata  = w_acc_inc;
    w_disp_we    = 1'b0;
    w_disp_waddr = r_dbin1;
    w_hist_wdata = w_acc_q;
    w_cum_wdata  = w_cum_new;
    if (r_state == StDump) begin
      w_acc_raddr = r_cnt[BIN_W-1:0];
    end
    if (w_in_init) begin
      w_acc_we     = 1'b1;
      w_acc_waddr  = r_cnt[BIN_W-1:0];
      w_acc_wdata  = '0;
      w_disp_we    = 1'b1;
      w_disp_waddr = r_cnt[BIN_W-1:0];
      w_hist_wdata = '0;
      w_cum_wdata  = '0;
    end else if (r_dv1) begin
      w_acc_we    = 1'b1;
      w_acc_waddr = r_dbin1;
      w_acc_wdata = '0;
      w_disp_we   = 1'b1;
    end else if (r_v1) begin
      w_acc_we = 1'b1;
    end
  end

  always_ff @(posedge iPclk) begin
    if (iRst) begin
      r_state      <= StInit;
      r_cnt        <= '0;
      r_fval       <= 1'b0;
      r_armed      <= 1'b0;
      r_skip_pend  <= 1'b0;
      r_v1         <= 1'b0;
      r_bin1       <= '0;
      r_wv         <= 1'b0;
      r_wbin       <= '0;
      r_wdat       <= '0;
      r_dv1        <= 1'b0;
      r_dbin1      <= '0;
      r_cum_acc    <= '0;
      r_hist       <= '0;
      r_cum        <= '0;
      r_hist_bar   <= 1'b0;
      r_cum_bar    <= 1'b0;
      r_ready      <= 1'b0;
      r_frame_done <= 1'b0;
      r_skip       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_fval  <= iFval;
      if (w_in_acc && w_rise) begin
        r_armed <= 1'b1;
      end else if (w_fall) begin
        r_armed <= 1'b0;
      end
      // Any frame not armed by an in-ACC rising edge is ignored and flagged at its end.
      if (w_fall) begin
        r_skip_pend <= 1'b0;
      end else if (iFval && !r_armed && !(w_in_acc && w_rise)) begin
        r_skip_pend <= 1'b1;
      end
      r_skip  <= w_fall & r_skip_pend;
      r_v1    <= w_pix_v;
      r_bin1  <= w_pix_bin;
      r_wv    <= w_acc_we & ~w_in_init & ~r_dv1;
      r_wbin  <= w_acc_waddr;
      r_wdat  <= w_acc_wdata;
      r_dv1   <= w_dump_rd;
      r_dbin1 <= r_cnt[BIN_W-1:0];
      if (w_dump_last || w_in_init) begin
        r_cum_acc <= '0;
      end else if (r_dv1) begin
        r_cum_acc <= w_cum_new;
      end
      if (w_state_next != StAcc) begin
        r_ready <= 1'b0;
      end else if (w_dump_last) begin
        r_ready <= 1'b1;
      end
      r_frame_done <= w_dump_last;
      r_hist       <= w_hist_q;
      r_cum        <= w_cum_q;
      r_hist_bar   <= CUM_W'(w_hist_q) > iBar_lvl;
      r_cum_bar    <= w_cum_q > iBar_lvl;
    end
  end

  histo_dpram #(.WIDTH(CNT_W), .DEPTH_LOG2(BIN_W)) u_acc_mem (
    .i_clk  (iPclk),
    .i_we   (w_acc_we),
    .i_waddr(w_acc_waddr),
    .i_wdata(w_acc_wdata),
    .i_raddr(w_acc_raddr),
    .o_rdata(w_acc_q)
  );

  histo_dpram #(.WIDTH(CNT_W), .DEPTH_LOG2(BIN_W)) u_hist_mem (
    .i_clk  (iPclk),
    .i_we   (w_disp_we),
    .i_waddr(w_disp_waddr),
    .i_wdata(w_hist_wdata),
    .i_raddr(iRd_bin),
    .o_rdata(w_hist_q)
  );

  histo_dpram #(.WIDTH(CUM_W), .DEPTH_LOG2(BIN_W)) u_cum_mem (
    .i_clk  (iPclk),
    .i_we   (w_disp_we),
    .i_waddr(w_disp_waddr),
    .i_wdata(w_cum_wdata),
    .i_raddr(iRd_bin),
    .o_rdata(w_cum_q)
  );

`ifdef HISTO_PEAK_EN
  logic [BIN_W-1:0] r_run_bin, r_peak_bin, w_new_bin;
  logic [CNT_W-1:0] r_run_cnt, r_peak_cnt, w_new_cnt;
  logic             w_take;

  // Strict compare over an ascending sweep keeps the lowest bin on ties.
  assign w_take    = (r_dbin1 == '0) || (w_acc_q > r_run_cnt);
  assign w_new_bin = w_take ? r_dbin1 : r_run_bin;
  assign w_new_cnt = w_take ? w_acc_q : r_run_cnt;

  always_ff @(posedge iPclk) begin
    if (iRst) begin
      r_run_bin  <= '0;
      r_run_cnt  <= '0;
      r_peak_bin <= '0;
      r_peak_cnt <= '0;
    end else if (r_dv1) begin
      r_run_bin <= w_new_bin;
      r_run_cnt <= w_new_cnt;
      if (w_dump_last) begin
        r_peak_bin <= w_new_bin;
        r_peak_cnt <= w_new_cnt;
      end
    end
  end

  assign oPeak_bin = r_peak_bin;
  assign oPeak_cnt = r_peak_cnt;
`else
  assign oPeak_bin = '0;
  assign oPeak_cnt = '0;
`endif

  assign oHist       = r_hist;
  assign oCum        = r_cum;
  assign oHist_bar   = r_hist_bar;
  assign oCum_bar    = r_cum_bar;
  assign oReady      = r_ready;
  assign oFrame_done = r_frame_done;
  assign oSkip       = r_skip;
  assign oState      = r_state;

endmodule

// File: tb/tb_histo_engine.sv
// Directed bench: two engines share stimulus, one with default widths and one with
// 4-bit bin counts so saturation is visible alongside the normal counts.
module tb_histo_engine;

  logic        clk = 1'b0;
  logic        rst, fval, dval;
  logic [7:0]  pix, rd_bin;
  logic [23:0] bar;

  logic [19:0] a_hist, a_peak_cnt;
  logic [23:0] a_cum, b_cum;
  logic [3:0]  b_hist, b_peak_cnt;
  logic [7:0]  a_peak_bin, b_peak_bin;
  logic [1:0]  a_state, b_state;
  logic        a_hbar, a_cbar, a_ready, a_done, a_skip;
  logic        b_hbar, b_cbar, b_ready, b_done, b_skip;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  histo_engine u_dut_a (
    .iPclk(clk), .iRst(rst), .iFval(fval), .iDval(dval), .iPix(pix), .iRd_bin(rd_bin),
    .iBar_lvl(bar), .oHist(a_hist), .oCum(a_cum), .oHist_bar(a_hbar), .oCum_bar(a_cbar),
    .oReady(a_ready), .oFrame_done(a_done), .oSkip(a_skip), .oState(a_state),
    .oPeak_bin(a_peak_bin), .oPeak_cnt(a_peak_cnt)
  );

  histo_engine #(.PIX_W(8), .BIN_W(8), .CNT_W(4), .CUM_W(24)) u_dut_b (
    .iPclk(clk), .iRst(rst), .iFval(fval), .iDval(dval), .iPix(pix), .iRd_bin(rd_bin),
    .iBar_lvl(bar), .oHist(b_hist), .oCum(b_cum), .oHist_bar(b_hbar), .oCum_bar(b_cbar),
    .oReady(b_ready), .oFrame_done(b_done), .oSkip(b_skip), .oState(b_state),
    .oPeak_bin(b_peak_bin), .oPeak_cnt(b_peak_cnt)
  );

  typedef struct {
    int          frame;
    logic [7:0]  bin;
    logic [23:0] lvl;
    logic [31:0] hist, cum, hist4, cum4;
    logic        hbar, cbar, hbar4;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < 600 && seen == 0; i++) begin
      tick();
      if (a_done === 1'b1) seen = 1;
    end
    chk({name, " frame_done"}, 32'(seen), 32'd1);
    chk({name, " ready_a"}, 32'(a_ready), 32'd1);
    chk({name, " ready_b"}, 32'(b_ready), 32'd1);
  endtask

  // Sends one armed frame and leaves the engine in DUMP; caller waits for completion.
  task automatic send_frame(input string name, input logic [7:0] pq[$]);
    fval = 1'b1;
    tick();
    foreach (pq[i]) begin
      dval = 1'b1;
      pix  = pq[i];
      tick();
    end
    dval = 1'b0;
    fval = 1'b0;
    tick();
    chk({name, " state_dump"}, 32'(a_state), 32'd2);
    chk({name, " ready_in_dump"}, 32'(a_ready), 32'd0);
  endtask

  task automatic check_vecs(input int frame);
    foreach (vecs[i]) begin
      if (vecs[i].frame == frame) begin
        rd_bin = vecs[i].bin;
        bar    = vecs[i].lvl;
        tick();
        tick();
        chk($sformatf("f%0d bin%02h hist", frame, vecs[i].bin), 32'(a_hist), vecs[i].hist);
        chk($sformatf("f%0d bin%02h cum", frame, vecs[i].bin), 32'(a_cum), vecs[i].cum);
        chk($sformatf("f%0d bin%02h hist4", frame, vecs[i].bin), 32'(b_hist), vecs[i].hist4);
        chk($sformatf("f%0d bin%02h cum4", frame, vecs[i].bin), 32'(b_cum), vecs[i].cum4);
        chk($sformatf("f%0d bin%02h hbar", frame, vecs[i].bin), 32'(a_hbar), 32'(vecs[i].hbar));
        chk($sformatf("f%0d bin%02h cbar", frame, vecs[i].bin), 32'(a_cbar), 32'(vecs[i].cbar));
        chk($sformatf("f%0d bin%02h hbar4", frame, vecs[i].bin), 32'(b_hbar),
            32'(vecs[i].hbar4));
      end
    end
  endtask

  initial begin
    logic [7:0] pq[$];
    int         skips;

    //                  frame bin    lvl  hist cum  h4  c4  hb  cb  hb4
    vecs.push_back(vec_t'{0, 8'h00, 24'd0,   0,   0,  0,  0, 0, 0, 0});
    vecs.push_back(vec_t'{0, 8'hFF, 24'd0,   0,   0,  0,  0, 0, 0, 0});
    vecs.push_back(vec_t'{1, 8'h36, 24'd0,   0,   0,  0,  0, 0, 0, 0});
    vecs.push_back(vec_t'{1, 8'h37, 24'd14,  100, 100, 15, 15, 1, 1, 1});
    vecs.push_back(vec_t'{1, 8'h37, 24'd15,  100, 100, 15, 15, 1, 1, 0});
    vecs.push_back(vec_t'{1, 8'hFF, 24'd99,  0,   100, 0,  15, 0, 1, 0});
    vecs.push_back(vec_t'{2, 8'h0F, 24'd0,   0,   0,  0,  0, 0, 0, 0});
    vecs.push_back(vec_t'{2, 8'h10, 24'd149, 150, 150, 15, 15, 1, 1, 0});
    vecs.push_back(vec_t'{2, 8'h20, 24'd50,  50,  200, 15, 30, 0, 1, 0});
    vecs.push_back(vec_t'{2, 8'h37, 24'd0,   0,   200, 0,  30, 0, 1, 0});
    vecs.push_back(vec_t'{2, 8'hFF, 24'd200, 0,   200, 0,  30, 0, 0, 0});
    vecs.push_back(vec_t'{3, 8'h05, 24'd29,  30,  30, 15, 15, 1, 1, 0});
    vecs.push_back(vec_t'{3, 8'h80, 24'd0,   0,   30, 0,  15, 0, 1, 0});
    vecs.push_back(vec_t'{3, 8'h90, 24'd30,  30,  60, 15, 30, 0, 1, 0});
    vecs.push_back(vec_t'{3, 8'hFF, 24'd59,  0,   60, 0,  30, 0, 1, 0});

    rst = 1'b1; fval = 1'b0; dval = 1'b0; pix = '0; rd_bin = '0; bar = '0;
    tick();
    tick();
    chk("reset state", 32'(a_state), 32'd0);
    chk("reset ready", 32'(a_ready), 32'd0);
    chk("reset done", 32'(a_done), 32'd0);
    chk("reset skip", 32'(a_skip), 32'd0);
    chk("reset hist", 32'(a_hist), 32'd0);
    chk("reset cum", 32'(a_cum), 32'd0);
    chk("reset peak_bin", 32'(a_peak_bin), 32'd0);

    rst = 1'b0;
    for (int i = 0; i < 255; i++) tick();
    chk("init cycle 255 state", 32'(a_state), 32'd0);
    tick();
    chk("init cycle 256 state", 32'(a_state), 32'd1);
    chk("init cycle 256 ready", 32'(a_ready), 32'd0);
    tick();

    // Frame 0: empty.
    pq.delete();
    send_frame("f0", pq);
    wait_done("f0");
    check_vecs(0);

    // Frame 1: 100 back-to-back identical pixels exercise write forwarding.
    pq.delete();
    for (int i = 0; i < 100; i++) pq.push_back(8'h37);
    send_frame("f1", pq);
    wait_done("f1");
    check_vecs(1);

    // Frame 2: mixed pattern, then a frame raised during DUMP that must be skipped.
    pq.delete();
    for (int i = 0; i < 50; i++) begin
      pq.push_back(8'h10); pq.push_back(8'h10); pq.push_back(8'h20); pq.push_back(8'h10);
    end
    send_frame("f2", pq);
    for (int i = 0; i < 5; i++) tick();
    fval = 1'b1; dval = 1'b1; pix = 8'h80;
    wait_done("f2");
    for (int i = 0; i < 20; i++) tick();
    chk("skip none before fall", 32'(a_skip), 32'd0);
    fval = 1'b0; dval = 1'b0;
    skips = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (a_skip === 1'b1) skips++;
    end
    chk("skip pulse count", 32'(skips), 32'd1);
    check_vecs(2);

    // Frame 3: tied peak bins; skipped pixels must not have leaked into bin 0x80.
    pq.delete();
    for (int i = 0; i < 30; i++) pq.push_back(8'h05);
    for (int i = 0; i < 30; i++) pq.push_back(8'h90);
    send_frame("f3", pq);
    wait_done("f3");
    check_vecs(3);
`ifdef HISTO_PEAK_EN
    chk("peak_bin a", 32'(a_peak_bin), 32'h05);
    chk("peak_cnt a", 32'(a_peak_cnt), 32'd30);
    chk("peak_bin b", 32'(b_peak_bin), 32'h05);
    chk("peak_cnt b", 32'(b_peak_cnt), 32'd15);
`else
    chk("peak_bin a", 32'(a_peak_bin), 32'd0);
    chk("peak_cnt a", 32'(a_peak_cnt), 32'd0);
    chk("peak_bin b", 32'(b_peak_bin), 32'd0);
    chk("peak_cnt b", 32'(b_peak_cnt), 32'd0);
`endif

    // Reset mid-frame returns to INIT and drops the ready flag.
    fval = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("mid-frame reset state", 32'(a_state), 32'd0);
    chk("mid-frame reset ready", 32'(a_ready), 32'd0);
    rst = 1'b0; fval = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/histo_engine.md
Name: histo_engine

Overview:
- Parametrised successor to the single-frame greyscale histogram unit in the camera pipeline.
- Accumulates a per-frame histogram of pixel intensities into configurable bins.
- At frame end, makes one combined sweep that publishes per-bin and cumulative counts to display memories and clears the accumulator.
- Adds a read-modify-write hazard bypass, count saturation, frame-skip detection, an explicit ready flag, and threshold bar outputs for the VGA overlay.

Parameters:
PIX_W, 8, input pixel width
BIN_W, 8, log2 of bin count; bin index = iPix[PIX_W-1 -: BIN_W]; requires BIN_W <= PIX_W
CNT_W, 20, per-bin count width; saturates at all-ones
CUM_W, 24, cumulative count width; saturates at all-ones

Ports:
iPclk  in  1  pixel clock, sole clock
iRst  in  1  synchronous, active-high reset
iFval  in  1  frame valid
iDval  in  1  data valid, qualified by iFval
iPix  in  PIX_W  pixel intensity
iRd_bin  in  BIN_W  display read address, e.g. iY_cont[BIN_W-1:0]
iBar_lvl  in  CUM_W  bar threshold, e.g. iX_cont zero-extended
oHist  out  CNT_W  published count of iRd_bin
oCum  out  CUM_W  published cumulative count, bins 0..iRd_bin
oHist_bar  out  1  oHist > iBar_lvl
oCum_bar  out  1  oCum > iBar_lvl
oReady  out  1  display memories hold a complete frame
oFrame_done  out  1  one-cycle pulse at end of DUMP
oSkip  out  1  one-cycle pulse when a frame is ignored
oState  out  2  current state encoding
oPeak_bin  out  BIN_W  see Optional Feature
oPeak_cnt  out  CNT_W  see Optional Feature

Behaviour:
- Reset:
  - state=INIT, sweep counter=0.
  - All outputs 0.
  - oReady stays 0 until the first DUMP completes.
- States (oState): INIT=0, ACC=1, DUMP=2. Encoding 3 is illegal and recovers to INIT.
- INIT:
  - Writes 0 to accumulator, hist and cum memories at addresses 0..2^BIN_W-1, one per cycle.
  - Lasts 2^BIN_W cycles, then goes to ACC.
- ACC:
  - Frame armed only if the iFval rising edge is seen while in ACC.
  - A frame already in progress on entry to ACC is ignored, and oSkip pulses at its falling edge.
  - An armed frame counts a pixel on each cycle with iFval&iDval.
  - Pipeline: read the accumulator at bin b on cycle t; write q+1 at cycle t+1, saturating at 2^CNT_W-1.
  - Memory read-during-write returns old data. If the stage-1 bin equals the pending write bin, the pending write value is forwarded instead of q.
  - So back-to-back identical pixels count exactly.
- ACC to DUMP:
  - Falling edge of iFval on an armed frame is registered.
  - DUMP starts on the following cycle, so the last pixel write commits first.
- DUMP:
  - oReady=0 for the whole state.
  - Sweep k=0..2^BIN_W-1 reads the accumulator.
  - One cycle later, for bin k:
    - hist[k] <= q;
    - cum[k] <= sat(cum_acc+q), and the running accumulator updates to that value;
    - acc[k] <= 0.
  - Duration 2^BIN_W+1 cycles.
  - On the last write: oFrame_done pulses, oReady=1, running cumulative cleared, return to ACC.
  - iFval/iDval during DUMP are ignored, and that frame is marked skipped.
- Display read:
  - iRd_bin at cycle t gives oHist/oCum at t+2 (memory read, then output register).
  - Bars are compared on the memory output and registered, so they align with oHist/oCum.
  - Outputs are undefined-but-stable while oReady=0.
- iRst mid-frame or mid-DUMP: returns to INIT immediately, clears all memories, oReady=0.

Optional Feature:
- Macro: HISTO_PEAK_EN.
- Defined:
  - During DUMP, track the maximum q and its bin; ties go to the lower bin.
  - oPeak_bin/oPeak_cnt are registered at the oFrame_done cycle and held until the next DUMP ends.
  - Reset value 0.
- Undefined: no tracking logic; oPeak_bin and oPeak_cnt tied to 0.

Decomposition:
- Package histo_pkg:
  - state encoding constants (INIT/ACC/DUMP);
  - saturating-add function;
  - NBINS helper (1<<BIN_W).
- Sub-module histo_dpram:
  - simple dual-port RAM, parameters WIDTH and DEPTH_LOG2;
  - registered read, old-data on read-during-write;
  - instantiated three times: accumulator, hist, cum.

Test Plan:
- Reset, then wait 256 cycles -> oState goes 0 to 1 at cycle 256; oReady=0; reading any bin after the first DUMP of an empty frame gives oHist=0, oCum=0.
- Frame of 100 pixels value 0x37, back to back with iDval=1 -> after oFrame_done, bin 0x37 oHist=100; oCum=0 for bins <0x37 and 100 for bins >=0x37 (checks forwarding).
- Alternating pixels 0x10,0x10,0x20,0x10 x50 -> bin 0x10 oHist=150, bin 0x20 oHist=50, oCum at 0xFF=200; the next frame starts from zero (clear verified).
- Raise iFval during DUMP -> that frame is ignored, oSkip pulses at its falling edge; the next full frame counts correctly.
- CNT_W=4, 20 pixels in one bin -> oHist=15 (saturated); oHist_bar=1 with iBar_lvl=14 and 0 with iBar_lvl=15, two cycles after iRd_bin.
- HISTO_PEAK_EN: 30 pixels each in bins 0x05 and 0x90 -> oPeak_bin=0x05, oPeak_cnt=30. Without the macro -> both 0.
